multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, driving the PC, instruction-register, register-file, ALU and memory enables. It consumes the opcode/funct3 fields from the instruction field decoder and the ALU branch-condition flag. It owns the instruction and data memory request/ready handshakes, including a watchdog on each.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for ready before a bus-error trap
TO_W, $clog2(MEM_TIMEOUT+1), width of the wait counter

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
opcode  in  7  instruction[6:0] from field decoder
funct3  in  3  instruction[14:12]; forwarded to ALU decode; no state effect
branch_cond  in  1  ALU comparison result, valid in EXECUTE
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write enable (store)
ir_write  out  1  latch instruction register
pc_write  out  1  update PC
pc_src  out  2  00 PC+4, 01 branch target, 10 JAL target, 11 JALR target
alu_src_imm  out  1  ALU operand B = immediate
alu_op  out  2  00 add (address), 01 compare (branch), 10 funct-decoded
reg_write  out  1  register-file write strobe
wb_sel  out  2  00 ALU, 01 load data, 10 PC+4
instr_retired  out  1  one-cycle pulse per completed instruction
halted  out  1  core stopped in TRAP
trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP. Registered state; all outputs are combinational from state, opcode and handshake inputs (Moore plus ready qualification).
- Reset (rst_n=0 at an edge): state=FETCH, wait counter=0, trap_cause=00. Reset takes effect from any state, including mid-handshake. While in reset, all outputs are 0 except imem_req, which is 0 during reset and 1 from the first cycle after reset.
- FETCH:
  - imem_req=1, held until imem_ready=1.
  - On ready: ir_write=1, pc_write=1, pc_src=00 in the same cycle; next state DECODE; counter cleared.
  - While waiting, counter increments. On reaching MEM_TIMEOUT: next state TRAP, trap_cause=10.
- DECODE: one cycle, operands read.
  - Supported opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR.
  - Supported opcode -> EXECUTE. Any other opcode -> TRAP, trap_cause=01.
- EXECUTE: one cycle.
  - R-type: alu_op=10, alu_src_imm=0 -> WRITEBACK.
  - I-ALU: alu_op=10, alu_src_imm=1 -> WRITEBACK.
  - Load/store: alu_op=00, alu_src_imm=1 -> MEMORY.
  - Branch: alu_op=01. If branch_cond=1: pc_write=1, pc_src=01. Then instr_retired=1 -> FETCH.
  - JAL: pc_write=1, pc_src=10 -> WRITEBACK. JALR: pc_write=1, pc_src=11 -> WRITEBACK.
- MEMORY:
  - dmem_req=1 (dmem_we=1 for store), held until dmem_ready.
  - Load on ready -> WRITEBACK.
  - Store on ready: instr_retired=1 -> FETCH.
  - Timeout as in FETCH -> TRAP, trap_cause=11.
- WRITEBACK: reg_write=1 for exactly one cycle; instr_retired=1 -> FETCH.
  - wb_sel=01 for load, 10 for JAL/JALR, 00 otherwise.
- TRAP: halted=1, every strobe 0, trap_cause held. Exits only via reset.
- Latched opcode: the opcode is captured into a register at the DECODE edge and used for all later states, so IR changes cannot corrupt sequencing.
- Ready before request: a ready arriving in a cycle with no matching request is ignored.
- Ready on the timeout cycle: a ready on the same cycle the counter hits MEM_TIMEOUT wins; no trap is taken.
- Cycle counts with zero-wait memory: R/I/JAL = 4, branch = 3, store = 4, load = 5.

Decomposition:
- Package ctrl_pkg holds:
  - State enum (3-bit).
  - Opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR).
  - pc_src, alu_op, wb_sel and trap_cause encodings.
- Sub-module mem_wait_timer, instanced once and shared by FETCH and MEMORY. Interface: start/clear, count enable, expired flag.

Test Plan:
- R-type: opcode=0110011, imem_ready tied 1. Sequence FETCH,DECODE,EXECUTE,WRITEBACK,FETCH. reg_write high exactly in cycle 4; instr_retired in cycle 4; wb_sel=00.
- Load: opcode=0000011, dmem_ready asserted 3 cycles after dmem_req. dmem_req high 4 cycles, dmem_we=0; then WRITEBACK with wb_sel=01. Total 8 cycles.
- Branch, taken and untaken: opcode=1100011.
  - branch_cond=1: pc_write=1, pc_src=01 in EXECUTE.
  - branch_cond=0: only FETCH pc_write. Both take 3 cycles; reg_write never asserted.
- Illegal opcode 1111111: TRAP after DECODE; halted=1, trap_cause=01. No further imem_req for 20 cycles. rst_n=0 for one cycle returns to FETCH with trap_cause=00.
- Timeouts:
  - imem_ready held 0: TRAP exactly MEM_TIMEOUT=16 cycles after FETCH entry, trap_cause=10.
  - Store with dmem_ready held 0: trap_cause=11.
  - dmem_ready on cycle 16: no trap.
- Reset mid-MEMORY: store waiting, rst_n=0 for one cycle. Next cycle state=FETCH, dmem_req=0, no instr_retired; normal fetch resumes.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer:
// state codes, major opcodes and the select/cause encodings it drives.
package multicycle_ctrl_fsm_pkg;

    // Sequencer states (3-bit, legacy-compatible constants)
    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_EXECUTE   = 3'd2;
    localparam logic [2:0] ST_MEMORY    = 3'd3;
    localparam logic [2:0] ST_WRITEBACK = 3'd4;
    localparam logic [2:0] ST_TRAP      = 3'd5;

    // RV32I major opcodes handled by the sequencer
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Next-PC source
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Register-file write-back source
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    // Trap causes
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM    = 2'b10;
    localparam logic [1:0] TRAP_DMEM    = 2'b11;

    // True for the opcodes this core can sequence
    function automatic logic is_supported(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: is_supported = 1'b1;
            default:                    is_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/handshake bundle between the sequencer (master) and the
// datapath plus instruction/data memories (slave).
interface multicycle_ctrl_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_cond;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_imm;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       instr_retired;
    logic       halted;
    logic [1:0] trap_cause;

    modport master (
        input  opcode, funct3, branch_cond, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
               alu_src_imm, alu_op, reg_write, wb_sel, instr_retired,
               halted, trap_cause
    );

    modport slave (
        output opcode, funct3, branch_cond, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
               alu_src_imm, alu_op, reg_write, wb_sel, instr_retired,
               halted, trap_cause
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Watchdog for a memory handshake. Counts consecutive cycles a request
// waits without ready; expired is raised on the MEM_TIMEOUT-th waiting
// cycle so the sequencer can trap on that edge unless ready arrives.
module multicycle_ctrl_fsm_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0] ONE       = TO_W'(1);

    logic [TO_W-1:0] count_r;

    // Wait counter: restarts on clear, saturates at the last waiting cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {TO_W{1'b0}};
        end else if (clear) begin
            count_r <= {TO_W{1'b0}};
        end else if (count_en && (count_r != LAST_WAIT)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = count_en && (count_r == LAST_WAIT);
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core: FETCH, DECODE,
// EXECUTE, MEMORY, WRITEBACK with a sticky TRAP. Outputs are decoded from
// the registered state, the opcode latched at DECODE and the ready inputs.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_ctrl_fsm_if.master bus
);
    logic [2:0] state_r, next_state_s;
    logic [6:0] opcode_r;
    logic [1:0] trap_cause_r, trap_cause_next_s;
    logic       timer_en_s, timer_clear_s, timer_expired_s;

    logic       imem_req_s, dmem_req_s, dmem_we_s, ir_write_s, pc_write_s;
    logic [1:0] pc_src_s, alu_op_s, wb_sel_s;
    logic       alu_src_imm_s, reg_write_s, instr_retired_s, halted_s;

    // funct3 is decoded by the ALU, not by the sequencer
    logic unused_funct3_s;
    assign unused_funct3_s = ^bus.funct3;

    // One watchdog serves both handshakes; only one can be waiting at a time
    assign timer_en_s    = ((state_r == ST_FETCH)  && !bus.imem_ready) ||
                           ((state_r == ST_MEMORY) && !bus.dmem_ready);
    assign timer_clear_s = !timer_en_s;

    multicycle_ctrl_fsm_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_mem_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear_s),
        .count_en (timer_en_s),
        .expired  (timer_expired_s)
    );

    // Next-state and trap-cause selection; ready beats the watchdog
    always_comb begin
        next_state_s      = state_r;
        trap_cause_next_s = trap_cause_r;
        case (state_r)
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    next_state_s = ST_DECODE;
                end else if (timer_expired_s) begin
                    next_state_s      = ST_TRAP;
                    trap_cause_next_s = TRAP_IMEM;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (is_supported(bus.opcode)) begin
                    next_state_s = ST_EXECUTE;
                end else begin
                    next_state_s      = ST_TRAP;
                    trap_cause_next_s = TRAP_ILLEGAL;
                end
            end
            ST_EXECUTE: begin
                case (opcode_r)
                    OP_LOAD, OP_STORE: next_state_s = ST_MEMORY;
                    OP_BRANCH:         next_state_s = ST_FETCH;
                    default:           next_state_s = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                if (bus.dmem_ready) begin
                    next_state_s = (opcode_r == OP_STORE) ? ST_FETCH : ST_WRITEBACK;
                end else if (timer_expired_s) begin
                    next_state_s      = ST_TRAP;
                    trap_cause_next_s = TRAP_DMEM;
                end else begin
                    next_state_s = ST_MEMORY;
                end
            end
            ST_WRITEBACK: next_state_s = ST_FETCH;
            ST_TRAP:      next_state_s = ST_TRAP;
            default:      next_state_s = ST_FETCH;
        endcase
    end

    // State, latched opcode and trap cause; reset wins from any state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_FETCH;
            opcode_r     <= 7'b0000000;
            trap_cause_r <= TRAP_NONE;
        end else begin
            state_r      <= next_state_s;
            trap_cause_r <= trap_cause_next_s;
            if (state_r == ST_DECODE) begin
                opcode_r <= bus.opcode;
            end else begin
                opcode_r <= opcode_r;
            end
        end
    end

    // Per-state strobe decode, qualified by the matching ready
    always_comb begin
        imem_req_s      = 1'b0;
        dmem_req_s      = 1'b0;
        dmem_we_s       = 1'b0;
        ir_write_s      = 1'b0;
        pc_write_s      = 1'b0;
        pc_src_s        = PC_PLUS4;
        alu_src_imm_s   = 1'b0;
        alu_op_s        = ALU_ADD;
        reg_write_s     = 1'b0;
        wb_sel_s        = WB_ALU;
        instr_retired_s = 1'b0;
        halted_s        = 1'b0;
        case (state_r)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (bus.imem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    pc_src_s   = PC_PLUS4;
                end else begin
                    ir_write_s = 1'b0;
                    pc_write_s = 1'b0;
                end
            end
            ST_DECODE: begin
                halted_s = 1'b0;
            end
            ST_EXECUTE: begin
                case (opcode_r)
                    OP_R:   alu_op_s = ALU_FUNCT;
                    OP_IMM: begin
                        alu_op_s      = ALU_FUNCT;
                        alu_src_imm_s = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_op_s      = ALU_ADD;
                        alu_src_imm_s = 1'b1;
                    end
                    OP_BRANCH: begin
                        alu_op_s        = ALU_CMP;
                        instr_retired_s = 1'b1;
                        if (bus.branch_cond) begin
                            pc_write_s = 1'b1;
                            pc_src_s   = PC_BRANCH;
                        end else begin
                            pc_write_s = 1'b0;
                        end
                    end
                    OP_JAL: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = PC_JAL;
                    end
                    OP_JALR: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = PC_JALR;
                    end
                    default: alu_op_s = ALU_ADD;
                endcase
            end
            ST_MEMORY: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (opcode_r == OP_STORE);
                if (bus.dmem_ready && (opcode_r == OP_STORE)) begin
                    instr_retired_s = 1'b1;
                end else begin
                    instr_retired_s = 1'b0;
                end
            end
            ST_WRITEBACK: begin
                reg_write_s     = 1'b1;
                instr_retired_s = 1'b1;
                case (opcode_r)
                    OP_LOAD:         wb_sel_s = WB_LOAD;
                    OP_JAL, OP_JALR: wb_sel_s = WB_PC4;
                    default:         wb_sel_s = WB_ALU;
                endcase
            end
            ST_TRAP: halted_s = 1'b1;
            default: halted_s = 1'b0;
        endcase
    end

    // Everything reads as zero while reset is asserted
    assign bus.imem_req      = rst_n & imem_req_s;
    assign bus.dmem_req      = rst_n & dmem_req_s;
    assign bus.dmem_we       = rst_n & dmem_we_s;
    assign bus.ir_write      = rst_n & ir_write_s;
    assign bus.pc_write      = rst_n & pc_write_s;
    assign bus.pc_src        = rst_n ? pc_src_s : 2'b00;
    assign bus.alu_src_imm   = rst_n & alu_src_imm_s;
    assign bus.alu_op        = rst_n ? alu_op_s : 2'b00;
    assign bus.reg_write     = rst_n & reg_write_s;
    assign bus.wb_sel        = rst_n ? wb_sel_s : 2'b00;
    assign bus.instr_retired = rst_n & instr_retired_s;
    assign bus.halted        = rst_n & halted_s;
    assign bus.trap_cause    = rst_n ? trap_cause_r : TRAP_NONE;
endmodule
